// File: rtl/output_scheduler_if.sv
// Configuration bus between software registers and output_scheduler.
// master: register side (drives cfg_* fields and commit request)
// slave : scheduler side (returns commit_ack / commit_pending)
interface output_scheduler_if #(
  parameter int NCH          = 4,
  parameter int timer_length = 24
);
  logic                     cfg_wr;
  logic [$clog2(NCH)-1:0]   cfg_addr;
  logic                     cfg_enable;
  logic [7:0]               cfg_start_tooth;
  logic [7:0]               cfg_end_tooth;
  logic [timer_length-1:0]  cfg_start_counts;
  logic [timer_length-1:0]  cfg_end_counts;
  logic                     cfg_commit;
  logic                     commit_ack;
  logic                     commit_pending;

  modport master (
    output cfg_wr, cfg_addr, cfg_enable, cfg_start_tooth, cfg_end_tooth,
           cfg_start_counts, cfg_end_counts, cfg_commit,
    input  commit_ack, commit_pending
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_enable, cfg_start_tooth, cfg_end_tooth,
           cfg_start_counts, cfg_end_counts, cfg_commit,
    output commit_ack, commit_pending
  );
endinterface

// File: rtl/output_scheduler.sv
// Output scheduler: shadow/active event table with atomic commit at the
// engine-cycle boundary (tooth 0), sync-gated driver enables, and a
// per-channel maximum on-time guard with latched lockout.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   tooth_num/edge      : tooth index and single-cycle tooth strobe
//   sync_valid          : decoder has crank sync
//   cfg (slave)         : shadow write port, commit request, ack/pending
//   max_on_counts       : on-time limit in clk cycles, 0 disables guard
//   fault_clr           : per-channel lockout clear
//   drv_en, drv_*       : driver enables and active-table parameters
//   drv_out             : raw driver outputs
//   ch_out, fault       : gated pins and lockout status
module output_scheduler #(
  parameter int NCH          = 4,
  parameter int timer_length = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  tooth_num,
  input  logic                        tooth_edge,
  input  logic                        sync_valid,
  output_scheduler_if.slave           cfg,
  input  logic [timer_length-1:0]     max_on_counts,
  input  logic [NCH-1:0]              fault_clr,
  output logic [NCH-1:0]              drv_en,
  output logic [8*NCH-1:0]            drv_start_tooth,
  output logic [8*NCH-1:0]            drv_end_tooth,
  output logic [timer_length*NCH-1:0] drv_start_counts,
  output logic [timer_length*NCH-1:0] drv_end_counts,
  input  logic [NCH-1:0]              drv_out,
  output logic [NCH-1:0]              ch_out,
  output logic [NCH-1:0]              fault
);
  localparam int TL = timer_length;

  logic [NCH-1:0]    sh_en, act_en;
  logic [8*NCH-1:0]  sh_st, sh_et, act_st, act_et;
  logic [TL*NCH-1:0] sh_sc, sh_ec, act_sc, act_ec;
  logic              pending, ack;
  logic [NCH-1:0]    lockout;
  logic [TL-1:0]     on_cnt [NCH];
  logic              apply;

  // Without sync no events can be in flight, so the copy need not wait
  // for tooth 0. Only an already-registered request qualifies, which is
  // what pushes a request arriving on a boundary edge to the next one.
  assign apply = pending && (!sync_valid || (tooth_edge && tooth_num == 8'd0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_en   <= '0;
      sh_st   <= '0;
      sh_et   <= '0;
      sh_sc   <= '0;
      sh_ec   <= '0;
      act_en  <= '0;
      act_st  <= '0;
      act_et  <= '0;
      act_sc  <= '0;
      act_ec  <= '0;
      pending <= 1'b0;
      ack     <= 1'b0;
    end else begin
      ack <= apply;
      if (apply) begin
        pending <= 1'b0;
        // Non-blocking reads take the shadow before any same-cycle write.
        act_en  <= sh_en;
        act_st  <= sh_st;
        act_et  <= sh_et;
        act_sc  <= sh_sc;
        act_ec  <= sh_ec;
      end else if (cfg.cfg_commit) begin
        pending <= 1'b1;
      end
      if (cfg.cfg_wr) begin
        sh_en[cfg.cfg_addr]            <= cfg.cfg_enable;
        sh_st[8*cfg.cfg_addr +: 8]     <= cfg.cfg_start_tooth;
        sh_et[8*cfg.cfg_addr +: 8]     <= cfg.cfg_end_tooth;
        sh_sc[TL*cfg.cfg_addr +: TL]   <= cfg.cfg_start_counts;
        sh_ec[TL*cfg.cfg_addr +: TL]   <= cfg.cfg_end_counts;
      end
    end
  end

  // Dwell guard: trip when the counter reaches the limit while still on,
  // giving max_on_counts+1 high cycles before the pin is forced low.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) begin
        on_cnt[c]  <= '0;
        lockout[c] <= 1'b0;
      end else begin
        if (fault_clr[c] || !drv_out[c])
          on_cnt[c] <= '0;
        else if (on_cnt[c] != '1)
          on_cnt[c] <= on_cnt[c] + TL'(1);
        if (fault_clr[c])
          lockout[c] <= 1'b0;
        else if (max_on_counts != '0 && drv_out[c] && on_cnt[c] == max_on_counts)
          lockout[c] <= 1'b1;
      end
    end
  end

  assign drv_en             = act_en & {NCH{sync_valid}} & ~lockout;
  assign ch_out             = drv_out & ~lockout;
  assign fault              = lockout;
  assign drv_start_tooth    = act_st;
  assign drv_end_tooth      = act_et;
  assign drv_start_counts   = act_sc;
  assign drv_end_counts     = act_ec;
  assign cfg.commit_ack     = ack;
  assign cfg.commit_pending = pending;
endmodule

// File: tb/tb_output_scheduler.sv
module tb_output_scheduler;
  localparam int NCH = 4;
  localparam int TL  = 24;

  typedef struct packed {
    logic          en;
    logic [7:0]    st;
    logic [7:0]    et;
    logic [TL-1:0] sc;
    logic [TL-1:0] ec;
  } entry_t;
  typedef entry_t [NCH-1:0] table_t;

  typedef struct {
    logic d;
    logic clr;
    logic exp_ch;
    logic exp_f;
  } dw_t;

  logic              clk;
  logic              reset_n;
  logic [7:0]        tooth_num;
  logic              tooth_edge;
  logic              sync_valid;
  logic [TL-1:0]     max_on_counts;
  logic [NCH-1:0]    fault_clr;
  logic [NCH-1:0]    drv_en;
  logic [8*NCH-1:0]  drv_start_tooth, drv_end_tooth;
  logic [TL*NCH-1:0] drv_start_counts, drv_end_counts;
  logic [NCH-1:0]    drv_out;
  logic [NCH-1:0]    ch_out;
  logic [NCH-1:0]    fault;

  output_scheduler_if #(.NCH(NCH), .timer_length(TL)) cfg ();

  output_scheduler #(.NCH(NCH), .timer_length(TL)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .tooth_num        (tooth_num),
    .tooth_edge       (tooth_edge),
    .sync_valid       (sync_valid),
    .cfg              (cfg.slave),
    .max_on_counts    (max_on_counts),
    .fault_clr        (fault_clr),
    .drv_en           (drv_en),
    .drv_start_tooth  (drv_start_tooth),
    .drv_end_tooth    (drv_end_tooth),
    .drv_start_counts (drv_start_counts),
    .drv_end_counts   (drv_end_counts),
    .drv_out          (drv_out),
    .ch_out           (ch_out),
    .fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  table_t m_shadow;
  table_t cur;
  table_t sb[$];
  dw_t    tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] bus_of(table_t t, int sel);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      case (sel)
        0:       r[8*c +: 8]   = t[c].st;
        1:       r[8*c +: 8]   = t[c].et;
        2:       r[TL*c +: TL] = t[c].sc;
        3:       r[TL*c +: TL] = t[c].ec;
        default: r[c]          = t[c].en;
      endcase
    end
    return r;
  endfunction

  task automatic cfg_write(int addr, entry_t e);
    cfg.cfg_wr           = 1'b1;
    cfg.cfg_addr         = 2'(addr);
    cfg.cfg_enable       = e.en;
    cfg.cfg_start_tooth  = e.st;
    cfg.cfg_end_tooth    = e.et;
    cfg.cfg_start_counts = e.sc;
    cfg.cfg_end_counts   = e.ec;
    m_shadow[addr]       = e;
    tick();
    cfg.cfg_wr = 1'b0;
  endtask

  task automatic request_commit();
    sb.push_back(m_shadow);
    cfg.cfg_commit = 1'b1;
    tick();
    cfg.cfg_commit = 1'b0;
  endtask

  task automatic tooth(int n);
    tooth_num  = 8'(n);
    tooth_edge = 1'b1;
    tick();
    tooth_edge = 1'b0;
  endtask

  // Called one sample point after the expected apply edge.
  task automatic apply_check(string nm);
    table_t t;
    chk({nm, " ack"}, 128'(cfg.commit_ack), 128'd1);
    chk({nm, " pending"}, 128'(cfg.commit_pending), 128'd0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty queue want entry", nm);
    end else begin
      t = sb.pop_front();
      cur = t;
      chk({nm, " start_tooth"},  128'(drv_start_tooth),  bus_of(t, 0));
      chk({nm, " end_tooth"},    128'(drv_end_tooth),    bus_of(t, 1));
      chk({nm, " start_counts"}, 128'(drv_start_counts), bus_of(t, 2));
      chk({nm, " end_counts"},   128'(drv_end_counts),   bus_of(t, 3));
      chk({nm, " drv_en"}, 128'(drv_en), bus_of(t, 4) & {128{sync_valid}});
    end
  endtask

  initial begin
    int  cnt;
    logic tripped;

    // Dwell-guard vectors on ch3 with max_on_counts=2; outputs sampled
    // before the edge of each row.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};

    m_shadow = '0;
    cur      = '0;

    // Reset with arbitrary inputs.
    reset_n              = 1'b0;
    tooth_num            = 8'($urandom);
    tooth_edge           = 1'b1;
    sync_valid           = 1'b1;
    cfg.cfg_wr           = 1'b1;
    cfg.cfg_addr         = 2'($urandom);
    cfg.cfg_enable       = 1'b1;
    cfg.cfg_start_tooth  = 8'($urandom);
    cfg.cfg_end_tooth    = 8'($urandom);
    cfg.cfg_start_counts = 24'($urandom);
    cfg.cfg_end_counts   = 24'($urandom);
    cfg.cfg_commit       = 1'b1;
    max_on_counts        = '0;
    fault_clr            = 4'($urandom);
    drv_out              = '0;
    tick();
    tick();
    chk("rst drv_en", 128'(drv_en), 128'd0);
    chk("rst ch_out", 128'(ch_out), 128'd0);
    chk("rst fault", 128'(fault), 128'd0);
    chk("rst start_tooth", 128'(drv_start_tooth), 128'd0);
    chk("rst pending", 128'(cfg.commit_pending), 128'd0);
    chk("rst ack", 128'(cfg.commit_ack), 128'd0);

    reset_n        = 1'b1;
    tooth_edge     = 1'b0;
    tooth_num      = 8'd0;
    cfg.cfg_wr     = 1'b0;
    cfg.cfg_commit = 1'b0;
    fault_clr      = '0;
    tick();
    chk("post rst end_counts", 128'(drv_end_counts), 128'd0);
    drv_out = 4'b1111;
    #1;
    chk("ch_out follows drv_out", 128'(ch_out), 128'hf);
    chk("drv_en zero table", 128'(drv_en), 128'd0);
    drv_out = '0;

    // Deferred commit.
    cfg_write(0, '{1'b1, 8'd3, 8'd4, 24'd10, 24'd20});
    cfg_write(1, '{1'b1, 8'd5, 8'd9, 24'd100, 24'd200});
    chk("shadow invisible", 128'(drv_start_tooth), 128'd0);
    sb.push_back(m_shadow);
    cfg.cfg_commit = 1'b1;
    tooth_num      = 8'd17;
    tooth_edge     = 1'b1;
    tick();
    cfg.cfg_commit = 1'b0;
    tooth_edge     = 1'b0;
    chk("defer pending", 128'(cfg.commit_pending), 128'd1);
    chk("defer no ack", 128'(cfg.commit_ack), 128'd0);
    for (int t = 18; t <= 20; t++) begin
      tooth(t);
      chk("defer hold", 128'(drv_start_counts), 128'd0);
    end
    tooth_num  = 8'd0;
    tooth_edge = 1'b1;
    #1;
    chk("defer before apply", 128'(drv_end_tooth), 128'd0);
    tick();
    tooth_edge = 1'b0;
    apply_check("deferred");
    tick();
    chk("ack one cycle", 128'(cfg.commit_ack), 128'd0);

    // Commit request on the boundary edge itself.
    cfg_write(2, '{1'b1, 8'd20, 8'd30, 24'd1000, 24'd2000});
    sb.push_back(m_shadow);
    cfg.cfg_commit = 1'b1;
    tooth_num      = 8'd0;
    tooth_edge     = 1'b1;
    tick();
    cfg.cfg_commit = 1'b0;
    tooth_edge     = 1'b0;
    chk("coll1 pending", 128'(cfg.commit_pending), 128'd1);
    tick();
    chk("coll1 no ack", 128'(cfg.commit_ack), 128'd0);
    chk("coll1 old table", 128'(drv_start_tooth), bus_of(cur, 0));
    tooth(1);
    tooth(2);
    tooth(0);
    apply_check("coll1");

    // Shadow write in the apply cycle stays in the shadow.
    request_commit();
    cfg.cfg_wr           = 1'b1;
    cfg.cfg_addr         = 2'd2;
    cfg.cfg_enable       = 1'b1;
    cfg.cfg_start_tooth  = 8'd7;
    cfg.cfg_end_tooth    = 8'd30;
    cfg.cfg_start_counts = 24'd1000;
    cfg.cfg_end_counts   = 24'd2000;
    m_shadow[2].st       = 8'd7;
    tooth_num            = 8'd0;
    tooth_edge           = 1'b1;
    tick();
    cfg.cfg_wr = 1'b0;
    tooth_edge = 1'b0;
    apply_check("coll2");

    // Commit without sync applies the next cycle.
    sync_valid = 1'b0;
    #1;
    chk("sync loss drv_en", 128'(drv_en), 128'd0);
    request_commit();
    chk("nosync pending", 128'(cfg.commit_pending), 128'd1);
    tick();
    apply_check("nosync");
    sync_valid = 1'b1;
    #1;
    chk("sync back drv_en", 128'(drv_en), 128'h7);

    // Dwell guard table on ch3.
    max_on_counts = 24'd2;
    for (int i = 0; i < 13; i++) begin
      drv_out   = {tbl[i].d, 3'b000};
      fault_clr = {tbl[i].clr, 3'b000};
      #1;
      chk($sformatf("dwell row %0d ch_out", i), 128'(ch_out[3]), 128'(tbl[i].exp_ch));
      chk($sformatf("dwell row %0d fault", i), 128'(fault[3]), 128'(tbl[i].exp_f));
      tick();
    end
    drv_out   = '0;
    fault_clr = '0;

    // ch0 held on with max_on_counts=10.
    max_on_counts = 24'd10;
    tick();
    drv_out = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (ch_out[0]) cnt++;
      else break;
      tick();
    end
    chk("max on-time high cycles", 128'(cnt), 128'd11);
    chk("trip fault", 128'(fault[0]), 128'd1);
    chk("trip drv_en", 128'(drv_en[0]), 128'd0);
    fault_clr = 4'b0001;
    tick();
    fault_clr = '0;
    chk("clr fault", 128'(fault[0]), 128'd0);
    chk("clr drv_en", 128'(drv_en[0]), 128'd1);

    max_on_counts = '0;
    tripped = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fault[0] || !ch_out[0]) tripped = 1'b1;
    end
    chk("guard disabled", 128'(tripped), 128'd0);
    drv_out = '0;

    // Reset during a pending commit and an active lockout.
    max_on_counts = 24'd3;
    request_commit();
    drv_out = 4'b0010;
    for (int i = 0; i < 6; i++) tick();
    chk("pre-rst fault", 128'(fault), 128'h2);
    chk("pre-rst pending", 128'(cfg.commit_pending), 128'd1);
    reset_n = 1'b0;
    drv_out = '0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    m_shadow = '0;
    chk("midrst pending", 128'(cfg.commit_pending), 128'd0);
    chk("midrst fault", 128'(fault), 128'd0);
    chk("midrst start_counts", 128'(drv_start_counts), 128'd0);
    chk("midrst drv_en", 128'(drv_en), 128'd0);
    sync_valid = 1'b0;
    request_commit();
    tick();
    apply_check("midrst shadow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
